// File: rtl/adder_display_pkg.sv
// Shared types and constants for the adder result display: FSM states and
// active-low seven-segment patterns (bit order gfedcba).
package adder_display_pkg;

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_SHOW  = 2'd1,
    ST_FLASH = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 3-bit value to active-low seven-segment pattern.
module seg7_decode
  import adder_display_pkg::*;
(
  input  logic [2:0] value,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    unique case (value)
      3'd0: seg_n = SEG_0;
      3'd1: seg_n = SEG_1;
      3'd2: seg_n = SEG_2;
      3'd3: seg_n = SEG_3;
      3'd4: seg_n = SEG_4;
      3'd5: seg_n = SEG_5;
      3'd6: seg_n = SEG_6;
      3'd7: seg_n = SEG_7;
      default: seg_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/adder_result_display.sv
// Shows the Nios adder result on a seven-segment digit and flashes it
// for a fixed number of half-periods whenever the value changes.
module adder_result_display
  import adder_display_pkg::*;
#(
  parameter int BLINK_CYCLES  = 12500000,
  parameter int FLASH_TOGGLES = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] value_in,
  input  logic       enable,
  output logic [6:0] hex_n,
  output logic       led_changed,
  output logic [7:0] update_count
);

  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int TW = $clog2(FLASH_TOGGLES + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
  localparam logic [TW-1:0] TOGGLE_END = TW'(FLASH_TOGGLES);

  state_t        state_reg, state_next;
  logic [2:0]    value_q;
  logic [2:0]    shown_reg, shown_next;
  logic          lit_reg, lit_next;
  logic [BW-1:0] blink_reg, blink_next;
  logic [TW-1:0] toggle_reg, toggle_next;
  logic [7:0]    count_reg, count_next;
  logic [TW-1:0] toggle_inc;
  logic          chg;
  logic [6:0]    seg_shown;

  assign chg        = (value_q != shown_reg);
  assign toggle_inc = toggle_reg + TW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= ST_BLANK;
      value_q    <= 3'd0;
      shown_reg  <= 3'd0;
      lit_reg    <= 1'b0;
      blink_reg  <= '0;
      toggle_reg <= '0;
      count_reg  <= 8'd0;
    end else begin
      state_reg  <= state_next;
      value_q    <= value_in;
      shown_reg  <= shown_next;
      lit_reg    <= lit_next;
      blink_reg  <= blink_next;
      toggle_reg <= toggle_next;
      count_reg  <= count_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    shown_next  = shown_reg;
    lit_next    = lit_reg;
    blink_next  = blink_reg;
    toggle_next = toggle_reg;
    count_next  = count_reg;
    unique case (state_reg)
      ST_BLANK: begin
        // Track the input while blanked so re-enable shows it without a flash.
        shown_next  = value_q;
        lit_next    = 1'b0;
        blink_next  = '0;
        toggle_next = '0;
        if (enable) state_next = ST_SHOW;
      end
      ST_SHOW, ST_FLASH: begin
        if (!enable) begin
          state_next  = ST_BLANK;
          lit_next    = 1'b0;
          blink_next  = '0;
          toggle_next = '0;
        end else if (chg) begin
          state_next  = ST_FLASH;
          shown_next  = value_q;
          lit_next    = 1'b0;
          blink_next  = '0;
          toggle_next = '0;
          count_next  = sat_inc8(count_reg);
        end else if (state_reg == ST_FLASH) begin
          if (blink_reg == BLINK_LAST) begin
            blink_next  = '0;
            lit_next    = ~lit_reg;
            toggle_next = toggle_inc;
            if (toggle_inc == TOGGLE_END) begin
              state_next = ST_SHOW;
              lit_next   = 1'b1;
            end
          end else begin
            blink_next = blink_reg + BW'(1);
          end
        end
      end
      default: state_next = ST_BLANK;
    endcase
  end

  seg7_decode u_seg7_decode (
    .value (shown_reg),
    .seg_n (seg_shown)
  );

  assign hex_n = ((state_reg == ST_BLANK) || ((state_reg == ST_FLASH) && !lit_reg))
                 ? SEG_BLANK : seg_shown;
  assign led_changed  = (state_reg == ST_FLASH);
  assign update_count = count_reg;

endmodule

// File: tb/tb_adder_result_display.sv
// Randomised and directed checks of adder_result_display against a
// time-based reference model (BLINK_CYCLES=4, FLASH_TOGGLES=2).
module tb_adder_result_display;

  localparam int BC = 4;
  localparam int FT = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [2:0] value_in;
  logic [6:0] hex_n;
  logic       led_changed;
  logic [7:0] update_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adder_result_display #(.BLINK_CYCLES(BC), .FLASH_TOGGLES(FT)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .value_in     (value_in),
    .enable       (enable),
    .hex_n        (hex_n),
    .led_changed  (led_changed),
    .update_count (update_count)
  );

  logic [6:0] seg_ref [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

  // Model: mode 0=blank 1=show 2=flash; elapsed = cycles since flash entry.
  int m_vq, m_shown, m_mode, m_elapsed, m_count;

  function automatic logic [6:0] exp_hex();
    if (m_mode == 0) return 7'h7F;
    if (m_mode == 2 && ((m_elapsed / BC) % 2) == 0) return 7'h7F;
    return seg_ref[m_shown];
  endfunction

  task automatic model_reset();
    m_vq = 0; m_shown = 0; m_mode = 0; m_elapsed = 0; m_count = 0;
  endtask

  // One rising edge: model sees the inputs the DUT samples; returns at negedge.
  task automatic step();
    @(posedge clk);
    if (m_mode == 0) begin
      m_shown = m_vq;
      if (enable) m_mode = 1;
    end else if (!enable) begin
      m_mode = 0; m_elapsed = 0;
    end else if (m_vq != m_shown) begin
      m_shown = m_vq; m_mode = 2; m_elapsed = 0;
      m_count = (m_count < 255) ? m_count + 1 : 255;
    end else if (m_mode == 2) begin
      m_elapsed++;
      if (m_elapsed == BC * FT) m_mode = 1;
    end
    m_vq = int'(value_in);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b1; value_in = 3'd0;
    model_reset();
    #12;
    checks++;
    if (hex_n !== 7'h7F) begin failures++; $display("FAIL reset_hex actual=%h required=7f", hex_n); end
    checks++;
    if (update_count !== 8'd0) begin failures++; $display("FAIL reset_count actual=%0d required=0", update_count); end
    checks++;
    if (led_changed !== 1'b0) begin failures++; $display("FAIL reset_led actual=%b required=0", led_changed); end
    @(negedge clk);
    reset_n = 1'b1;
    step();
    checks++;
    if (hex_n !== 7'h40) begin failures++; $display("FAIL first_show_hex actual=%h required=40", hex_n); end
    $display("test_reset: hex=%h count=%0d", hex_n, update_count);
  endtask

  task automatic test_change();
    value_in = 3'd5;
    step(); step();
    checks++;
    if (led_changed !== 1'b1 || hex_n !== 7'h7F || update_count !== 8'd1) begin
      failures++;
      $display("FAIL change_entry actual=led%b/%h/%0d required=led1/7f/1", led_changed, hex_n, update_count);
    end
    repeat (4) step();
    checks++;
    if (hex_n !== 7'h12) begin failures++; $display("FAIL change_lit actual=%h required=12", hex_n); end
    repeat (4) step();
    checks++;
    if (led_changed !== 1'b0 || hex_n !== 7'h12) begin
      failures++;
      $display("FAIL change_done actual=led%b/%h required=led0/12", led_changed, hex_n);
    end
    $display("test_change: value 0->5 count=%0d", update_count);
  endtask

  task automatic test_restart();
    int c0;
    int led_cycles;
    value_in = 3'd1;
    repeat (11) step();
    value_in = 3'd5;
    repeat (8) step();
    checks++;
    if (hex_n !== 7'h12 || led_changed !== 1'b1) begin
      failures++;
      $display("FAIL restart_lit actual=led%b/%h required=led1/12", led_changed, hex_n);
    end
    c0 = int'(update_count);
    value_in = 3'd3;
    step(); step();
    checks++;
    if (int'(update_count) !== c0 + 1 || hex_n !== 7'h7F || led_changed !== 1'b1) begin
      failures++;
      $display("FAIL restart_entry actual=%0d/%h required=%0d/7f", update_count, hex_n, c0 + 1);
    end
    repeat (4) step();
    checks++;
    if (hex_n !== 7'h30) begin failures++; $display("FAIL restart_lit3 actual=%h required=30", hex_n); end
    led_cycles = 5;
    for (int i = 0; i < 10 && led_changed; i++) begin
      step();
      if (led_changed) led_cycles++;
    end
    checks++;
    if (led_cycles !== BC * FT) begin
      failures++;
      $display("FAIL restart_length actual=%0d required=%0d", led_cycles, BC * FT);
    end
    $display("test_restart: 5->3 count=%0d flash_cycles=%0d", update_count, led_cycles);
  endtask

  task automatic test_enable_chg();
    int c0;
    value_in = 3'd6;
    step(); step(); step();
    c0 = int'(update_count);
    value_in = 3'd2;
    step();
    enable = 1'b0;
    step();
    checks++;
    if (hex_n !== 7'h7F || led_changed !== 1'b0 || int'(update_count) !== c0) begin
      failures++;
      $display("FAIL enable_wins actual=%h/led%b/%0d required=7f/led0/%0d", hex_n, led_changed, update_count, c0);
    end
    enable = 1'b1;
    step();
    step(); step();
    checks++;
    if (hex_n !== 7'h24 || led_changed !== 1'b0 || int'(update_count) !== c0) begin
      failures++;
      $display("FAIL reenable_show actual=%h/led%b/%0d required=24/led0/%0d", hex_n, led_changed, update_count, c0);
    end
    $display("test_enable_chg: blank then show hex=%h count=%0d", hex_n, update_count);
  endtask

  task automatic test_saturate();
    logic [2:0] v;
    for (int i = 0; i < 300; i++) begin
      v = value_in ^ 3'(1 + $urandom_range(0, 6));
      value_in = v;
      repeat (11) step();
      checks++;
      if (int'(update_count) !== m_count || hex_n !== exp_hex()) begin
        failures++;
        $display("FAIL saturate_step%0d actual=%0d/%h required=%0d/%h", i, update_count, hex_n, m_count, exp_hex());
      end
    end
    checks++;
    if (update_count !== 8'd255) begin failures++; $display("FAIL saturate_final actual=%0d required=255", update_count); end
    $display("test_saturate: 300 changes count=%0d", update_count);
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 6) enable = ~enable;
      if ($urandom_range(0, 99) < 15) value_in = 3'($urandom_range(0, 7));
      step();
      checks++;
      if (hex_n !== exp_hex() || led_changed !== (m_mode == 2) || int'(update_count) !== m_count) begin
        failures++;
        $display("FAIL random_cyc%0d actual=%h/led%b/%0d required=%h/led%b/%0d",
                 i, hex_n, led_changed, update_count, exp_hex(), (m_mode == 2), m_count);
      end
    end
    $display("test_random: 1500 cycles count=%0d", update_count);
  endtask

  task automatic test_async_reset();
    enable = 1'b1;
    value_in = value_in + 3'd1;
    repeat (4) step();
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (hex_n !== 7'h7F || led_changed !== 1'b0 || update_count !== 8'd0) begin
      failures++;
      $display("FAIL async_reset actual=%h/led%b/%0d required=7f/led0/0", hex_n, led_changed, update_count);
    end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (hex_n !== exp_hex() || led_changed !== (m_mode == 2) || int'(update_count) !== m_count) begin
        failures++;
        $display("FAIL post_reset_cyc%0d actual=%h/led%b/%0d required=%h/led%b/%0d",
                 i, hex_n, led_changed, update_count, exp_hex(), (m_mode == 2), m_count);
      end
    end
    $display("test_async_reset: hex=%h count=%0d", hex_n, update_count);
  endtask

  initial begin
    test_reset();
    test_change();
    test_restart();
    test_enable_chg();
    test_saturate();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
